pc_sequencer: RTL and testbench

Next-PC and return-address-stack unit for the 19-bit single-cycle core. Consumes the controller's `pc_src`, `stack_push` and `stack_pop` decisions plus the current instruction word. Holds the program counter and a hardware subroutine stack. Drives the instruction-memory address each cycle.

---
 rtl/scmips_pkg.sv | 32 +++
 rtl/pc_sequencer_if.sv | 30 +++
 rtl/return_stack.sv | 65 ++++++
 rtl/pc_sequencer.sv | 79 +++++++
 tb/tb_pc_sequencer.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/scmips_pkg.sv
// scmips_pkg: shared definitions for the 19-bit single-cycle core's
// next-PC logic.
//   - pc_src_e    : next-PC selection codes driven by the controller
//   - INSTR_W     : instruction word width
//   - JMP_OPC     : opcode prefix that marks an absolute jump
//   - field bounds: opcode prefix, absolute jump field, branch offset
//   - is_jump()   : decodes the absolute-jump prefix from an instruction
package scmips_pkg;

  localparam int INSTR_W = 19;

  typedef enum logic [1:0] {
    PC_SEQ  = 2'b00,
    PC_TAKE = 2'b01,
    PC_RET  = 2'b10,
    PC_RSVD = 2'b11
  } pc_src_e;

  localparam logic [3:0] JMP_OPC = 4'b1110;

  localparam int OPC_MSB  = 18;
  localparam int OPC_LSB  = 15;
  localparam int JMP_MSB  = 11;
  localparam int JMP_LSB  = 0;
  localparam int BOFF_MSB = 7;
  localparam int BOFF_LSB = 0;

  function automatic logic is_jump(input logic [INSTR_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB] == JMP_OPC;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: controller <-> PC sequencer bundle.
//   master (controller side): drives instruction, pc_src, stack_push,
//     stack_pop; observes pc, sp, stack_full, stack_empty, stack_err.
//   slave (pc_sequencer): the reverse.
interface pc_sequencer_if #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 8
);
  import scmips_pkg::*;

  logic [INSTR_W-1:0]      instruction;
  logic [1:0]              pc_src;
  logic                    stack_push;
  logic                    stack_pop;
  logic [ADDR_W-1:0]       pc;
  logic [$clog2(DEPTH):0]  sp;
  logic                    stack_full;
  logic                    stack_empty;
  logic                    stack_err;

  modport master (
    output instruction, pc_src, stack_push, stack_pop,
    input  pc, sp, stack_full, stack_empty, stack_err
  );

  modport slave (
    input  instruction, pc_src, stack_push, stack_pop,
    output pc, sp, stack_full, stack_empty, stack_err
  );
endinterface

// File: rtl/return_stack.sv
// return_stack: hardware subroutine return-address stack.
//   clk, rst  : clock, asynchronous active-high reset (clears sp only)
//   push, pop : stack requests; both high is a conflict and is ignored
//   wdata     : return address written on a successful push
//   top       : asynchronous read of the top entry (mem[sp-1])
//   sp        : number of valid entries
//   full/empty: decodes of sp
//   err_pulse : this cycle's request overflows, underflows or conflicts
module return_stack #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [ADDR_W-1:0]      wdata,
  output logic [ADDR_W-1:0]      top,
  output logic [$clog2(DEPTH):0] sp,
  output logic                   full,
  output logic                   empty,
  output logic                   err_pulse
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int SP_W  = IDX_W + 1;

  // Entries are not reset: only sp defines which ones are meaningful.
  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [IDX_W-1:0]  top_idx;
  logic              do_push, do_pop;

  always_comb begin
    full    = (sp_q == SP_W'(DEPTH));
    empty   = (sp_q == '0);
    do_push = push & ~pop & ~full;
    do_pop  = pop & ~push & ~empty;
    err_pulse = (push & pop) | (push & ~pop & full) | (pop & ~push & empty);
    // sp-1 wraps harmlessly when empty; top is ignored in that case.
    top_idx = sp_q[IDX_W-1:0] - IDX_W'(1);
    top     = mem_q[top_idx];
    sp_d    = sp_q;
    if (do_push) begin
      sp_d = sp_q + SP_W'(1);
    end else if (do_pop) begin
      sp_d = sp_q - SP_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[sp_q[IDX_W-1:0]] <= wdata;
    end
  end

  assign sp = sp_q;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and next-PC selection with a hardware
// return stack.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : pc_sequencer_if.slave -- instruction, pc_src, stack_push,
//              stack_pop in; pc, sp, stack_full, stack_empty and the
//              sticky stack_err out.
module pc_sequencer #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 8
) (
  input  logic           clk,
  input  logic           rst,
  pc_sequencer_if.slave  bus
);
  import scmips_pkg::*;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] seq, jump_tgt, br_tgt;
  logic [ADDR_W-1:0] st_top;
  logic              st_full, st_empty, st_err_pulse;
  logic              conflict, ret_underflow;
  logic              unused_instr_bits;

  // Bits between the opcode prefix and the jump field play no part here.
  assign unused_instr_bits = ^bus.instruction[OPC_LSB-1:JMP_MSB+1];

  return_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.stack_push),
    .pop       (bus.stack_pop),
    .wdata     (seq),
    .top       (st_top),
    .sp        (bus.sp),
    .full      (st_full),
    .empty     (st_empty),
    .err_pulse (st_err_pulse)
  );

  always_comb begin
    seq      = pc_q + ADDR_W'(1);
    // Size casts zero-extend / sign-extend or truncate to ADDR_W.
    jump_tgt = ADDR_W'(bus.instruction[JMP_MSB:JMP_LSB]);
    br_tgt   = seq + ADDR_W'($signed(bus.instruction[BOFF_MSB:BOFF_LSB]));
    conflict = bus.stack_push & bus.stack_pop;
    ret_underflow = (bus.pc_src == PC_RET) && st_empty;

    pc_d = seq;
    // A push/pop conflict forces the sequential path whatever pc_src says.
    if (!conflict) begin
      case (bus.pc_src)
        PC_TAKE: pc_d = is_jump(bus.instruction) ? jump_tgt : br_tgt;
        PC_RET:  pc_d = st_empty ? seq : st_top;
        default: pc_d = seq;
      endcase
    end

    err_d = err_q | st_err_pulse | ret_underflow;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.stack_full  = st_full;
  assign bus.stack_empty = st_empty;
  assign bus.stack_err   = err_q;
endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
  import scmips_pkg::*;

  logic clk;
  logic rst;

  pc_sequencer_if #(.ADDR_W(12), .DEPTH(8)) bus ();

  pc_sequencer #(.ADDR_W(12), .DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_before;
    logic [18:0] instr;
    logic [1:0]  src;
    logic        push;
    logic        pop;
    logic [11:0] pc;
    logic [3:0]  sp;
    logic        err;
  } vec_t;

  typedef struct packed {
    logic [11:0] pc;
    logic [3:0]  sp;
    logic        full;
    logic        empty;
    logic        err;
  } obs_t;

  vec_t vecs[$];
  obs_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [18:0] jmp(input logic [11:0] a);
    return {4'b1110, 3'b000, a};
  endfunction

  function automatic logic [18:0] br(input logic [7:0] o);
    return {4'b0100, 7'b0000000, o};
  endfunction

  function automatic obs_t mk_obs(input logic [11:0] pc, input logic [3:0] sp,
                                  input logic err);
    obs_t o;
    o.pc    = pc;
    o.sp    = sp;
    o.full  = (sp == 4'd8);
    o.empty = (sp == 4'd0);
    o.err   = err;
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.pc    = bus.pc;
    o.sp    = bus.sp;
    o.full  = bus.stack_full;
    o.empty = bus.stack_empty;
    o.err   = bus.stack_err;
    return o;
  endfunction

  task automatic add(input logic rb, input logic [18:0] instr, input logic [1:0] src,
                     input logic push, input logic pop, input logic [11:0] pc,
                     input logic [3:0] sp, input logic err);
    vec_t v;
    v.rst_before = rb;
    v.instr = instr;
    v.src   = src;
    v.push  = push;
    v.pop   = pop;
    v.pc    = pc;
    v.sp    = sp;
    v.err   = err;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input obs_t exp);
    obs_t act;
    act = dut_obs();
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got pc=%h sp=%0d full=%b empty=%b err=%b, want pc=%h sp=%0d full=%b empty=%b err=%b",
               name, act.pc, act.sp, act.full, act.empty, act.err,
               exp.pc, exp.sp, exp.full, exp.empty, exp.err);
    end
  endtask

  // Entered and left on a falling edge.
  task automatic apply(input vec_t v, input int idx);
    obs_t exp;
    string nm;
    if (v.rst_before) begin
      rst = 1'b1;
      #1;
      check($sformatf("reset_before_vec%0d", idx), mk_obs(12'h000, 4'd0, 1'b0));
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
    end
    bus.instruction = v.instr;
    bus.pc_src      = v.src;
    bus.stack_push  = v.push;
    bus.stack_pop   = v.pop;
    sb.push_back(mk_obs(v.pc, v.sp, v.err));
    @(posedge clk);
    #1;
    exp = sb.pop_front();
    nm = $sformatf("vec%0d", idx);
    check(nm, exp);
    $display("vec %0d instr=%h src=%0d push=%b pop=%b -> pc=%h sp=%0d err=%b",
             idx, v.instr, v.src, v.push, v.pop, bus.pc, bus.sp, bus.stack_err);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] ra;
    int k;
    rst = 1'b0;
    bus.instruction = '0;
    bus.pc_src      = PC_SEQ;
    bus.stack_push  = 1'b0;
    bus.stack_pop   = 1'b0;

    // Sequential, jumps, branches.
    add(1, 19'h0, PC_SEQ, 0, 0, 12'h001, 4'd0, 0);
    add(0, 19'h0, PC_SEQ, 0, 0, 12'h002, 4'd0, 0);
    add(0, 19'h0, PC_SEQ, 0, 0, 12'h003, 4'd0, 0);
    add(0, jmp(12'h010), PC_TAKE, 0, 0, 12'h010, 4'd0, 0);
    add(0, jmp(12'h0A5), PC_TAKE, 0, 0, 12'h0A5, 4'd0, 0);
    add(0, jmp(12'h020), PC_TAKE, 0, 0, 12'h020, 4'd0, 0);
    add(0, br(8'hFE),    PC_TAKE, 0, 0, 12'h01F, 4'd0, 0);
    add(0, br(8'h05),    PC_TAKE, 0, 0, 12'h025, 4'd0, 0);
    add(0, jmp(12'h005), PC_TAKE, 0, 0, 12'h005, 4'd0, 0);
    // JSB / RET pair.
    add(0, jmp(12'h100), PC_TAKE, 1, 0, 12'h100, 4'd1, 0);
    add(0, 19'h0,        PC_RET,  0, 1, 12'h006, 4'd0, 0);
    // Nine nested JSBs: the ninth overflows.
    for (int i = 0; i < 8; i++) begin
      add(0, jmp(12'(12'h200 + 16 * i)), PC_TAKE, 1, 0,
          12'(12'h200 + 16 * i), 4'(i + 1), 0);
    end
    add(0, jmp(12'h280), PC_TAKE, 1, 0, 12'h280, 4'd8, 1);
    // Eight RETs unwind in LIFO order.
    for (int j = 0; j < 8; j++) begin
      k  = 7 - j;
      ra = (k == 0) ? 12'h007 : 12'(12'h201 + 16 * (k - 1));
      add(0, 19'h0, PC_RET, 0, 1, ra, 4'(k), 1);
    end
    add(0, jmp(12'h123), PC_RSVD, 0, 0, 12'h008, 4'd0, 1);
    // RET on an empty stack.
    add(1, jmp(12'h030), PC_TAKE, 0, 0, 12'h030, 4'd0, 0);
    add(0, 19'h0,        PC_RET,  0, 1, 12'h031, 4'd0, 1);
    // Mismatched pc_src with push/pop, RET without pop, and a conflict.
    add(1, 19'h0,        PC_SEQ,  1, 0, 12'h001, 4'd1, 0);
    add(0, jmp(12'h040), PC_TAKE, 1, 0, 12'h040, 4'd2, 0);
    add(0, 19'h0,        PC_RET,  0, 0, 12'h002, 4'd2, 0);
    add(0, jmp(12'h300), PC_TAKE, 1, 1, 12'h003, 4'd2, 1);
    add(0, 19'h0,        PC_RET,  0, 1, 12'h002, 4'd1, 1);
    add(0, 19'h0,        PC_SEQ,  0, 1, 12'h003, 4'd0, 1);
    // Address wrap in both directions.
    add(1, jmp(12'hFFF), PC_TAKE, 0, 0, 12'hFFF, 4'd0, 0);
    add(0, 19'h0,        PC_SEQ,  0, 0, 12'h000, 4'd0, 0);
    add(0, br(8'hFE),    PC_TAKE, 0, 0, 12'hFFF, 4'd0, 0);
    add(0, 19'h0,        PC_SEQ,  0, 0, 12'h000, 4'd0, 0);
    // Build sp = 3 for the asynchronous reset sequence.
    add(0, 19'h0, PC_SEQ, 1, 0, 12'h001, 4'd1, 0);
    add(0, 19'h0, PC_SEQ, 1, 0, 12'h002, 4'd2, 0);
    add(0, 19'h0, PC_SEQ, 1, 0, 12'h003, 4'd3, 0);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], i);
    end

    // Asynchronous reset mid-cycle, well away from any rising edge.
    bus.stack_push = 1'b0;
    bus.stack_pop  = 1'b0;
    bus.pc_src     = PC_SEQ;
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", mk_obs(12'h000, 4'd0, 1'b0));
    $display("async reset at sp=3 -> pc=%h sp=%0d empty=%b", bus.pc, bus.sp, bus.stack_empty);
    @(negedge clk);
    rst = 1'b0;
    // Entries pushed before reset are gone: RET underflows.
    begin
      vec_t v;
      v.rst_before = 1'b0;
      v.instr = 19'h0;
      v.src   = PC_RET;
      v.push  = 1'b0;
      v.pop   = 1'b1;
      v.pc    = 12'h001;
      v.sp    = 4'd0;
      v.err   = 1'b1;
      apply(v, vecs.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
